// File: rtl/pc_next_sel_pkg.sv
// Shared definitions for the next-PC selector: width helper and the
// per-cycle update decision.
package pc_next_sel_pkg;

   localparam int NUM_SRC_DEF = 4;

   typedef enum logic [1:0] {
      DEC_SEQ,
      DEC_LIVE,
      DEC_PEND
   } pc_dec_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/pc_next_sel_prio_enc.sv
// Fixed-priority encoder: highest set bit of valid_i wins.
module pc_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 3
) (
   input  logic [N-1:0]  valid_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (valid_i[i]) begin
            idx_o = IW'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_next_sel.sv
// Registered next-PC selector: prioritised redirects, stall hold with
// redirect capture, and misaligned-target trapping.
module pc_next_sel
   import pc_next_sel_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               NUM_SRC      = NUM_SRC_DEF,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INCR         = 4,
   parameter int               ALIGN_BITS   = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             stall,
   input  logic [NUM_SRC-1:0]               src_valid,
   input  logic [NUM_SRC*WIDTH-1:0]         src_data,
   output logic [WIDTH-1:0]                 pc_o,
   output logic                             pc_valid_o,
   output logic [clog2(NUM_SRC+1)-1:0]      sel_o,
   output logic                             pending_o,
   output logic                             misalign_o,
   output logic [WIDTH-1:0]                 bad_addr_o
);

   localparam int               SEL_W   = clog2(NUM_SRC + 1);
   localparam logic [SEL_W-1:0] SEL_SEQ = SEL_W'(NUM_SRC);

   logic [SEL_W-1:0] hi_idx;
   logic             hi_any;
   logic [WIDTH-1:0] live_tgt;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             pend_q, pend_d;
   logic [SEL_W-1:0] pend_idx_q, pend_idx_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             mis_q, mis_d;
   logic [WIDTH-1:0] bad_q, bad_d;

   pc_dec_e          dec;
   logic [WIDTH-1:0] tgt;
   logic [SEL_W-1:0] tgt_idx;

   pc_prio_enc #(.N(NUM_SRC), .IW(SEL_W)) u_prio_enc (
      .valid_i (src_valid),
      .idx_o   (hi_idx),
      .any_o   (hi_any)
   );

   assign live_tgt = src_data[int'(hi_idx)*WIDTH +: WIDTH];

   always_comb begin
      pc_d       = pc_q;
      valid_d    = valid_q;
      sel_d      = sel_q;
      pend_d     = pend_q;
      pend_idx_d = pend_idx_q;
      pend_tgt_d = pend_tgt_q;
      mis_d      = 1'b0;
      bad_d      = bad_q;
      dec        = DEC_SEQ;
      tgt        = '0;
      tgt_idx    = SEL_SEQ;

      if (!valid_q) begin
         // first edge after reset only qualifies the reset vector
         valid_d = 1'b1;
      end else if (stall) begin
         if (hi_any && (!pend_q || hi_idx >= pend_idx_q)) begin
            pend_d     = 1'b1;
            pend_idx_d = hi_idx;
            pend_tgt_d = live_tgt;
         end
      end else begin
         pend_d = 1'b0;
         if (hi_any && (!pend_q || pend_idx_q < hi_idx)) begin
            dec     = DEC_LIVE;
            tgt     = live_tgt;
            tgt_idx = hi_idx;
         end else if (pend_q) begin
            dec     = DEC_PEND;
            tgt     = pend_tgt_q;
            tgt_idx = pend_idx_q;
         end

         if (dec == DEC_SEQ) begin
            pc_d  = pc_q + WIDTH'(INCR);
            sel_d = SEL_SEQ;
         end else if (|tgt[ALIGN_BITS-1:0]) begin
            mis_d = 1'b1;
            bad_d = tgt;
         end else begin
            pc_d  = tgt;
            sel_d = tgt_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         sel_q      <= SEL_SEQ;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         pend_tgt_q <= '0;
         mis_q      <= 1'b0;
         bad_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         sel_q      <= sel_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
         pend_tgt_q <= pend_tgt_d;
         mis_q      <= mis_d;
         bad_q      <= bad_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = valid_q;
   assign sel_o      = sel_q;
   assign pending_o  = pend_q;
   assign misalign_o = mis_q;
   assign bad_addr_o = bad_q;

endmodule
